// File: rtl/mdu_iter.sv
// Iterative RV32M multiply/divide unit: radix-2 shift-add multiply, restoring divide.
// Optional macro MDU_FAST_MUL_EN: single-cycle combinational multiply at accept.
module mdu_iter #(
  parameter int XLEN = 32
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [2:0]      op,
  input  logic [XLEN-1:0] src1,
  input  logic [XLEN-1:0] src2,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] result,
  output logic            busy
);
  localparam int CW = $clog2(XLEN + 1);

  typedef enum logic [1:0] {IDLE, CALC, FIN, DONE} state_t;

  state_t                state_q, state_d;
  logic [2:0]            op_q, op_d;
  logic                  neg_q, neg_d;
  logic [XLEN-1:0]       mcand_q, mcand_d;
  logic [2*XLEN-1:0]     acc_q, acc_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic [XLEN-1:0]       result_q, result_d;

  logic                  is_div, s1_signed, s2_signed, s1_neg, s2_neg, neg_in;
  logic                  div_zero, div_ovf;
  logic [XLEN-1:0]       mag1, mag2, special_res;
  logic [XLEN:0]         mul_sum, div_shift;
  logic [XLEN+1:0]       div_diff;
  logic [XLEN-1:0]       div_rem;
  logic [2*XLEN-1:0]     mul_next, div_next, acc_neg;
  logic [XLEN-1:0]       rem_neg, fin_res;

  assign is_div    = op[2];
  assign s1_signed = (op == 3'd1) || (op == 3'd2) || (op == 3'd4) || (op == 3'd6);
  assign s2_signed = (op == 3'd1) || (op == 3'd4) || (op == 3'd6);
  assign s1_neg    = s1_signed & src1[XLEN-1];
  assign s2_neg    = s2_signed & src2[XLEN-1];
  assign mag1      = s1_neg ? -src1 : src1;
  assign mag2      = s2_neg ? -src2 : src2;
  // Remainder follows the dividend's sign; quotient and products follow the sign XOR.
  assign neg_in    = (is_div && op[1]) ? s1_neg : (s1_neg ^ s2_neg);

  assign div_zero    = is_div && (src2 == '0);
  assign div_ovf     = is_div && !op[0] && (src1 == {1'b1, {(XLEN-1){1'b0}}}) && (src2 == '1);
  assign special_res = div_zero ? (op[1] ? src1 : '1) : (op[1] ? '0 : src1);

`ifdef MDU_FAST_MUL_EN
  logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
  assign fast_a    = {{XLEN{s1_neg}}, src1};
  assign fast_b    = {{XLEN{s2_neg}}, src2};
  assign fast_prod = fast_a * fast_b;
`endif

  // Multiply: acc = {partial high, remaining multiplier bits}; divide: acc = {remainder, quotient}.
  assign mul_sum   = {1'b0, acc_q[2*XLEN-1:XLEN]} + ({1'b0, mcand_q} & {(XLEN+1){acc_q[0]}});
  assign mul_next  = {mul_sum, acc_q[XLEN-1:1]};
  assign div_shift = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
  assign div_diff  = {1'b0, div_shift} - {2'b00, mcand_q};
  assign div_rem   = div_diff[XLEN+1] ? div_shift[XLEN-1:0] : div_diff[XLEN-1:0];
  assign div_next  = {div_rem, acc_q[XLEN-2:0], ~div_diff[XLEN+1]};

  assign acc_neg = -acc_q;
  assign rem_neg = -acc_q[2*XLEN-1:XLEN];

  always_comb begin
    fin_res = '0;
    case (op_q)
      3'd0, 3'd4, 3'd5: fin_res = neg_q ? acc_neg[XLEN-1:0] : acc_q[XLEN-1:0];
      3'd1, 3'd2, 3'd3: fin_res = neg_q ? acc_neg[2*XLEN-1:XLEN] : acc_q[2*XLEN-1:XLEN];
      default:          fin_res = neg_q ? rem_neg : acc_q[2*XLEN-1:XLEN];
    endcase
  end

  always_comb begin
    state_d  = state_q;
    op_d     = op_q;
    neg_d    = neg_q;
    mcand_d  = mcand_q;
    acc_d    = acc_q;
    cnt_d    = cnt_q;
    result_d = result_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          op_d    = op;
          neg_d   = neg_in;
          mcand_d = is_div ? mag2 : mag1;
          acc_d   = {{XLEN{1'b0}}, (is_div ? mag1 : mag2)};
          cnt_d   = CW'(XLEN);
          if (div_zero || div_ovf) begin
            result_d = special_res;
            state_d  = DONE;
`ifdef MDU_FAST_MUL_EN
          end else if (!is_div) begin
            result_d = (op == 3'd0) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
            state_d  = DONE;
`endif
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        acc_d = op_q[2] ? div_next : mul_next;
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) state_d = FIN;
      end
      FIN: begin
        result_d = fin_res;
        state_d  = DONE;
      end
      default: begin
        if (out_ready) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= IDLE;
      op_q     <= '0;
      neg_q    <= 1'b0;
      mcand_q  <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      mcand_q  <= mcand_d;
      acc_q    <= acc_d;
      cnt_q    <= cnt_d;
      result_q <= result_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign busy      = !in_ready;
  assign out_valid = (state_q == DONE);
  assign result    = result_q;
endmodule

// File: tb/tb_mdu_iter.sv
// Bench for mdu_iter: arithmetic reference model plus per-cycle compare of handshake, timing and result.
module tb_mdu_iter;
  localparam int XLEN = 32;

  logic        clk = 1'b0, rst = 1'b1, in_valid = 1'b0, out_ready = 1'b1;
  logic [2:0]  op = 3'd0;
  logic [31:0] src1 = '0, src2 = '0;
  logic        in_ready, out_valid, busy;
  logic [31:0] result;

  mdu_iter #(.XLEN(XLEN)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .op(op),
    .src1(src1), .src2(src2), .out_valid(out_valid), .out_ready(out_ready),
    .result(result), .busy(busy)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_err = 0;
  bit pending = 0, seen = 0, rnd_ready = 0;
  int cyc = 0, exp_lat = 0, acc_cnt = 0, edge_no = 0, acc_edge = 0, hs_edge = 0;
  logic [31:0] exp_res = '0, hs_res = '0, cur_a = '0, cur_b = '0;
  logic [2:0]  cur_op = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] model(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    logic signed [63:0] sa, sb, ubs;
    logic [63:0] ua, ub, p;
    logic ovf;
    sa  = {{32{a[31]}}, a};
    sb  = {{32{b[31]}}, b};
    ua  = {32'b0, a};
    ub  = {32'b0, b};
    ubs = ub;
    ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
    p   = '0;
    case (o)
      3'd0: p = ua * ub;
      3'd1: p = sa * sb;
      3'd2: p = sa * ubs;
      3'd3: p = ua * ub;
      default: ;
    endcase
    case (o)
      3'd0: return p[31:0];
      3'd1, 3'd2, 3'd3: return p[63:32];
      3'd4: begin
        if (b == 0) return 32'hFFFF_FFFF;
        if (ovf) return a;
        p = sa / sb;
        return p[31:0];
      end
      3'd5: return (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'd6: begin
        if (b == 0) return a;
        if (ovf) return 32'h0;
        p = sa % sb;
        return p[31:0];
      end
      default: return (b == 0) ? a : a % b;
    endcase
  endfunction

  // Latency = clock edges from the accept edge through the edge that raises out_valid.
  function automatic int exp_latency(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    if (o[2] && (b == 0 || (!o[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF))) return 1;
`ifdef MDU_FAST_MUL_EN
    if (!o[2]) return 1;
`endif
    return XLEN + 2;
  endfunction

  always @(posedge clk) begin
    edge_no++;
    if (rst) begin
      pending = 0;
      seen    = 0;
    end else begin
      if (pending) cyc++;
      if (out_valid && out_ready) begin
        hs_edge = edge_no;
        hs_res  = result;
        pending = 0;
        $display("op=%0d a=%h b=%h -> result=%h (latency %0d)", cur_op, cur_a, cur_b, result, exp_lat);
      end
      if (in_valid && in_ready) begin
        acc_cnt++;
        acc_edge = edge_no;
        pending  = 1;
        seen     = 0;
        cyc      = 1;
        exp_res  = model(op, src1, src2);
        exp_lat  = exp_latency(op, src1, src2);
        cur_op   = op;
        cur_a    = src1;
        cur_b    = src2;
      end
    end
  end

  always @(negedge clk) begin
    if (!rst) begin
      chk("busy", 32'(busy), 32'(!in_ready));
      chk("in_ready", 32'(in_ready), 32'(!pending));
      chk("out_valid", 32'(out_valid), 32'(pending && cyc >= exp_lat));
      if (out_valid && pending) begin
        if (!seen) begin
          seen = 1;
          chk("latency", 32'(cyc), 32'(exp_lat));
        end
        chk("result", result, exp_res);
      end
    end
  end

  always @(negedge clk) if (rnd_ready) out_ready = ($urandom_range(0, 3) != 0);

  task automatic start(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b);
    int n0;
    @(negedge clk);
    op = o; src1 = a; src2 = b; in_valid = 1'b1;
    n0 = acc_cnt;
    for (int i = 0; i < 200 && acc_cnt == n0; i++) @(negedge clk);
    if (acc_cnt == n0) chk("accept_timeout", 32'(acc_cnt), 32'(n0 + 1));
  endtask

  task automatic finish_op();
    in_valid = 1'b0;
    for (int i = 0; i < 300 && pending; i++) @(negedge clk);
    if (pending) chk("done_timeout", 32'(pending), 32'(0));
  endtask

  task automatic check_lit(input string name, input logic [2:0] o, input logic [31:0] a,
                           input logic [31:0] b, input logic [31:0] lit);
    chk({name, "_model"}, model(o, a, b), lit);
    start(o, a, b);
    finish_op();
    chk(name, hs_res, lit);
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0;
      1: return 32'hFFFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'($urandom_range(0, 15));
      default: return $urandom;
    endcase
  endfunction

  initial begin
    logic [31:0] held;
    int n0;
    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(in_ready), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_out_valid", 32'(out_valid), 32'(0));
    chk("rst_result", result, 32'h0);
    rst = 1'b0;

    check_lit("mul_7x-3", 3'd0, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB);
    check_lit("mulh_min", 3'd1, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000);
    check_lit("mulhsu_ff", 3'd2, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    check_lit("mulhu_ff", 3'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
    check_lit("div_-7/2", 3'd4, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD);
    check_lit("rem_-7/2", 3'd6, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF);
    check_lit("divu_big", 3'd5, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC);
    check_lit("div_by_0", 3'd4, 32'd5, 32'd0, 32'hFFFF_FFFF);
    check_lit("remu_by_0", 3'd7, 32'd5, 32'd0, 32'd5);
    check_lit("div_ovf", 3'd4, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000);
    check_lit("rem_ovf", 3'd6, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0);

    // Backpressure, with a second request held on the input throughout.
    out_ready = 1'b0;
    start(3'd4, 32'd1000, 32'd7);
    op = 3'd0; src1 = 32'd3; src2 = 32'd5;
    for (int i = 0; i < 100 && !out_valid; i++) @(negedge clk);
    held = result;
    n0 = acc_cnt;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("bp_out_valid", 32'(out_valid), 32'(1));
      chk("bp_in_ready", 32'(in_ready), 32'(0));
      chk("bp_result", result, held);
    end
    out_ready = 1'b1;
    for (int i = 0; i < 10 && acc_cnt == n0; i++) @(negedge clk);
    chk("bp_div_result", hs_res, 32'd142);
    chk("bp_reaccept_gap", 32'(acc_edge - hs_edge), 32'(1));
    finish_op();
    chk("bp_mul_result", hs_res, 32'd15);

    // Reset during CALC of a divide.
    start(3'd4, 32'd100, 32'd7);
    in_valid = 1'b0;
    repeat (9) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("mid_rst_in_ready", 32'(in_ready), 32'(1));
    chk("mid_rst_out_valid", 32'(out_valid), 32'(0));
    chk("mid_rst_result", result, 32'h0);
    check_lit("mul_after_rst", 3'd0, 32'd3, 32'd4, 32'd12);

    rnd_ready = 1'b1;
    for (int k = 0; k < 200; k++) begin
      logic [2:0] o;
      logic [31:0] a, b;
      o = 3'($urandom_range(0, 7));
      a = pick();
      b = pick();
      repeat ($urandom_range(0, 2)) @(negedge clk);
      start(o, a, b);
      finish_op();
    end
    rnd_ready = 1'b0;
    out_ready = 1'b1;

    repeat (3) @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/mdu_iter.md
# mdu_iter

Iterative RV32M multiply/divide unit beside the single-cycle ALU in the execute stage. Handles all eight M-extension operations, generalised to XLEN bits, with a valid/ready handshake on both sides, because a multi-cycle result cannot fit in one ALU cycle. The core stalls on `in_ready`/`out_valid`. The unit is non-pipelined, with one operation in flight.

## Interface
- `XLEN`, default 32: operand and result width. Must be even and ≥ 4.
- `clk` in 1: rising-edge clock.
- `rst` in 1: synchronous, active-high reset.
- `in_valid` in 1: request valid.
- `in_ready` out 1: unit can accept a request.
- `op` in 3: operation code, equal to funct3. 0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU.
- `src1` in XLEN: rs1 value (multiplicand or dividend).
- `src2` in XLEN: rs2 value (multiplier or divisor).
- `out_valid` out 1: result valid.
- `out_ready` in 1: consumer accepts the result.
- `result` out XLEN: operation result.
- `busy` out 1: high in any state other than IDLE.

## Operation
- **States:** IDLE, CALC, FIN, DONE.
- **Accept:** occurs on a clock edge where `in_valid && in_ready`. `in_ready` = (state == IDLE).
  - Capture `op`.
  - Capture operand magnitudes. src1 is signed for MULH, MULHSU, DIV, REM. src2 is signed for MULH, DIV, REM. All other operands are unsigned.
  - Record the result-negate flag.
  - Load the iteration counter with XLEN.
- **Special cases, resolved at accept:** the unit goes directly IDLE→DONE, skipping CALC and FIN.
  - Divide by zero: DIV/DIVU give all-ones. REM/REMU give src1.
  - Signed overflow (DIV/REM with src1 = most-negative and src2 = all-ones): DIV gives src1. REM gives 0.
- **CALC (multiply):** radix-2 shift-add, one bit per cycle, into a 2·XLEN accumulator.
- **CALC (divide):** restoring division, one quotient bit per cycle.
- **Counter:** decrements every CALC cycle. On the edge where counter == 1, the state moves to FIN.
- **FIN:** applies two's-complement negation if the flag is set, then selects the result.
  - MUL: low half.
  - MULH/MULHSU/MULHU: high half.
  - DIV/DIVU: quotient.
  - REM/REMU: remainder.
  - Sign rules: remainder takes the sign of the dividend. Quotient is negated when operand signs differ.
  - The result is registered and the state moves to DONE.
- **DONE:** `out_valid` = 1.
  - `result` is held stable until `out_valid && out_ready`.
  - On that edge the state moves to IDLE.
- **No overlap:** a new request cannot be accepted in the same cycle as the output handshake.
- **Backpressure:** while in DONE with `out_ready` = 0, the unit holds indefinitely. `in_valid` is ignored.
- **Arithmetic:** all internal arithmetic is XLEN/2·XLEN wide and unsigned on magnitudes. Overflow of the most-negative magnitude is handled by the XLEN+1-bit internal representation.

## Timing
- **Reset (sync, `rst` high at an edge):**
  - State goes to IDLE.
  - `in_ready` = 1 in the following cycle.
  - `out_valid` = 0, `busy` = 0, `result` = 0, counter = 0.
  - Reset mid-operation discards the in-flight operation. No `out_valid` is produced for it.
- **Iterative operation:** accept at edge E0. CALC occupies edges E1…E_XLEN. FIN runs at edge E_XLEN+1. `out_valid` is high from cycle XLEN+2 after the accept cycle (34 for XLEN = 32).
- **Special case:** `out_valid` is high in the cycle after accept (latency 1).
- **Minimum issue interval:** latency + 1 cycle. The IDLE cycle after the output handshake is mandatory.
- **Input hold rule:** `src1`/`src2`/`op` are sampled only at accept. They may change afterwards.
- **`busy`:** equals !`in_ready`.

## Configuration
- **`MDU_FAST_MUL_EN` defined:**
  - MUL/MULH/MULHSU/MULHU use a combinational XLEN+1 × XLEN+1 signed product at accept.
  - The selected half is registered, then IDLE→DONE, with `out_valid` one cycle after accept.
  - Divide behaviour is unchanged.
- **Undefined:** all multiplies use the iterative path (latency XLEN+2). No multiplier is inferred.

## Test plan
- **Multiply results:**
  - MUL 7 × −3 (0xFFFFFFFD) → `result` 0xFFFFFFEB.
  - MULH 0x80000000 × 0x80000000 → 0x40000000.
  - MULHSU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFF.
  - MULHU 0xFFFFFFFF × 0xFFFFFFFF → 0xFFFFFFFE.
  - Latency 34 cycles without the macro, 1 cycle with it.
- **Signed divide:**
  - DIV −7 (0xFFFFFFF9) / 2 → 0xFFFFFFFD.
  - REM same operands → 0xFFFFFFFF.
  - DIVU 0xFFFFFFF9 / 2 → 0x7FFFFFFC.
  - Latency 34 cycles.
- **Divide by zero:**
  - DIV 5 / 0 → 0xFFFFFFFF.
  - REMU 5 / 0 → 5.
  - `out_valid` one cycle after accept.
- **Signed overflow:**
  - DIV 0x80000000 / 0xFFFFFFFF → 0x80000000.
  - REM → 0.
  - `out_valid` one cycle after accept.
- **Backpressure:**
  - Hold `out_ready` = 0 for 10 cycles in DONE → `result` stable, `out_valid` = 1, `in_ready` = 0.
  - A held `in_valid` is not accepted until one cycle after the output handshake.
- **Reset mid-operation:**
  - Assert `rst` at CALC cycle 10 of a DIV → next cycle `in_ready` = 1, `out_valid` = 0, `result` = 0.
  - A following MUL 3 × 4 → 12 with normal latency.
